ddp_ring_admission_ctrl: RTL

Clocked admission controller and arbiter at the merge point of the DDP token ring. It chooses between new external packets and internal packets recirculating from the branch stage and forwards one packet at a time into the matching stage through a single-entry output buffer. It tracks how many packets are in the ring and stops external injection above a limit, so the ring cannot deadlock. It also supports a drain/quiesce mode.

---
 rtl/ddp_ring_admission_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ddp_ring_admission_ctrl.sv
// Merge-point arbiter for the DDP token ring: admits external packets,
// recirculates internal ones, tracks ring occupancy and supports quiesce.
module ddp_ring_admission_ctrl #(
    parameter int LIMIT      = 48,
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 7
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             EX_Send_in,
    input  logic [37:0]      EX_PACKET_IN,
    input  logic             IN_Send_in,
    input  logic [37:0]      IN_PACKET_IN,
    input  logic             Ack_in,
    input  logic             RET_in,
    input  logic             MATCH_in,
    input  logic             COPY_in,
    input  logic             DRAIN_req,
    output logic             Ack_out_EX,
    output logic             Ack_out_IN,
    output logic             Send_out,
    output logic [37:0]      PACKET_OUT,
    output logic [CNT_W-1:0] OCC,
    output logic             FULL,
    output logic             DRAINED,
    output logic             ERR
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int OW = CNT_W + 2;
    localparam logic [CNT_W-1:0] LIM  = CNT_W'(LIMIT);
    localparam logic [SW-1:0]    SMAX = SW'(STARVE_MAX);

    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] QUIET = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [SW-1:0]    starve_q;
    logic             send_q;
    logic [37:0]      pkt_q;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic             full_q;
    logic             err_q;

    logic             buf_free;
    logic             below;
    logic             run;
    logic             ext_ok;
    logic             grant_ex;
    logic             grant_in;
    logic [OW-1:0]    occ_sum;
    logic             under;
    logic             over;

    assign buf_free = !send_q || Ack_in;
    assign below    = occ_q < LIM;
    assign run      = state_q == RUN;
    assign ext_ok   = EX_Send_in && below && run;

    // External overrides internal priority only once it has starved
    assign grant_ex = !MR && buf_free && ext_ok &&
                      (!IN_Send_in || starve_q == SMAX);
    assign grant_in = !MR && buf_free && IN_Send_in && !grant_ex;

    // Two guard bits: top bit flags underflow, next one overflow
    assign occ_sum = {2'b00, occ_q} + OW'(grant_ex) + OW'(COPY_in)
                   - OW'(RET_in) - OW'(MATCH_in);
    assign under   = occ_sum[OW-1];
    assign over    = !occ_sum[OW-1] && occ_sum[OW-2];

    always_comb begin
        occ_d = occ_sum[CNT_W-1:0];
        if (under) occ_d = '0;
        else if (over) occ_d = '1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:   if (DRAIN_req) state_d = DRAIN;
            DRAIN: begin
                if (!DRAIN_req) state_d = RUN;
                else if (occ_q == '0 && !send_q && !IN_Send_in)
                    state_d = QUIET;
            end
            QUIET: if (!DRAIN_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            send_q   <= 1'b0;
            pkt_q    <= '0;
            occ_q    <= '0;
            full_q   <= 1'b0;
            err_q    <= 1'b0;
            starve_q <= '0;
            state_q  <= RUN;
        end else begin
            if (buf_free) begin
                send_q <= grant_ex || grant_in;
                if (grant_ex) pkt_q <= EX_PACKET_IN;
                else if (grant_in) pkt_q <= IN_PACKET_IN;
            end
            occ_q   <= occ_d;
            full_q  <= occ_d >= LIM;
            err_q   <= err_q || under || over;
            state_q <= state_d;
            // Denials from the limit or drain mode are deliberate
            if (grant_ex || !EX_Send_in) starve_q <= '0;
            else if (below && run && starve_q != SMAX)
                starve_q <= starve_q + SW'(1);
        end
    end

    assign Ack_out_EX = grant_ex;
    assign Ack_out_IN = grant_in;
    assign Send_out   = send_q;
    assign PACKET_OUT = pkt_q;
    assign OCC        = occ_q;
    assign FULL       = full_q;
    assign DRAINED    = state_q == QUIET;
    assign ERR        = err_q;

endmodule
